id_ex_stage: RTL and testbench

//  Decode stage of the 19-bit 4-stage CPU; consumer end of the fetch-stage interface. Takes InstrD/PCPlus1, reads 16x19 regfile.

---
 rtl/id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode stage: register read with EX/WB bypass, branch resolution with wrong-path squash,
// and the ID/EX pipeline register.
module id_ex_stage #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREG   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         InstrD,
    input  logic [ADDR_W-1:0]         PCPlus1,
    output logic                      BranchD,
    output logic [ADDR_W-1:0]         PCBranch_Addr,
    input  logic                      ex_wr_en,
    input  logic [$clog2(NREG)-1:0]   ex_wr_addr,
    input  logic [DATA_W-1:0]         ex_result,
    input  logic                      wb_en,
    input  logic [$clog2(NREG)-1:0]   wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic [4:0]                opE,
    output logic [$clog2(NREG)-1:0]   rdE,
    output logic [DATA_W-1:0]         srcAE,
    output logic [DATA_W-1:0]         srcBE,
    output logic [DATA_W-1:0]         stdataE,
    output logic                      regwriteE,
    output logic                      memreadE,
    output logic                      memwriteE
);
    localparam int unsigned RA_W  = $clog2(NREG);
    localparam int unsigned OP_W  = 5;
    localparam int unsigned IMM_W = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 5'h02;
    localparam logic [OP_W-1:0] OP_AND  = 5'h03;
    localparam logic [OP_W-1:0] OP_OR   = 5'h04;
    localparam logic [OP_W-1:0] OP_XOR  = 5'h05;
    localparam logic [OP_W-1:0] OP_ADDI = 5'h06;
    localparam logic [OP_W-1:0] OP_LD   = 5'h07;
    localparam logic [OP_W-1:0] OP_ST   = 5'h08;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'h09;
    localparam logic [OP_W-1:0] OP_BNE  = 5'h0A;
    localparam logic [OP_W-1:0] OP_JMP  = 5'h0B;

    logic [DATA_W-1:0] regs [NREG];
    logic              squash_q;

    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;
    logic [DATA_W-1:0] rd_val, rs1_val, rs2_val;
    logic              take;
    logic [ADDR_W-1:0] tgt;

    logic [OP_W-1:0]   nxt_op;
    logic [RA_W-1:0]   nxt_rd;
    logic [DATA_W-1:0] nxt_a, nxt_b, nxt_st;
    logic              nxt_rw, nxt_mr, nxt_mw;

    assign op    = InstrD[DATA_W-1 -: OP_W];
    assign rd    = InstrD[DATA_W-OP_W-1 -: RA_W];
    assign rs1   = InstrD[DATA_W-OP_W-RA_W-1 -: RA_W];
    assign rs2   = InstrD[IMM_W-1 -: RA_W];
    assign imm   = InstrD[IMM_W-1:0];
    assign imm_d = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_a = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Operand read: R0 is zero, EX result beats the writeback port, which beats the array.
    function automatic logic [DATA_W-1:0] read_op(input logic [RA_W-1:0] a,
                                                  input logic [DATA_W-1:0] rf_val);
        if (a == '0)                           return '0;
        else if (ex_wr_en && ex_wr_addr == a)  return ex_result;
        else if (wb_en && wb_addr == a)        return wb_data;
        else                                   return rf_val;
    endfunction

    assign rd_val  = read_op(rd,  regs[rd]);
    assign rs1_val = read_op(rs1, regs[rs1]);
    assign rs2_val = read_op(rs2, regs[rs2]);

    // Branch resolution, fed straight back to the fetch PC mux.
    always_comb begin
        take = 1'b0;
        tgt  = PCPlus1 + imm_a;
        case (op)
            OP_BEQ: take = (rd_val == rs1_val);
            OP_BNE: take = (rd_val != rs1_val);
            OP_JMP: begin
                take = 1'b1;
                tgt  = InstrD[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    assign BranchD       = !squash_q && take;
    assign PCBranch_Addr = BranchD ? tgt : PCPlus1;

    // Decode into next ID/EX contents; a squashed slot becomes an all-zero bubble.
    always_comb begin
        nxt_op = '0;
        nxt_rd = '0;
        nxt_a  = '0;
        nxt_b  = '0;
        nxt_st = '0;
        nxt_rw = 1'b0;
        nxt_mr = 1'b0;
        nxt_mw = 1'b0;
        if (!squash_q) begin
            nxt_rd = rd;
            nxt_a  = rs1_val;
            nxt_b  = rs2_val;
            if (op <= OP_JMP) nxt_op = op;
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: nxt_rw = 1'b1;
                OP_ADDI: begin
                    nxt_rw = 1'b1;
                    nxt_b  = imm_d;
                end
                OP_LD: begin
                    nxt_rw = 1'b1;
                    nxt_mr = 1'b1;
                    nxt_b  = imm_d;
                end
                OP_ST: begin
                    nxt_mw = 1'b1;
                    nxt_b  = imm_d;
                    nxt_st = rd_val;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Reset leaves squash set so the stale IF/ID slot after release is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_q  <= 1'b1;
            opE       <= '0;
            rdE       <= '0;
            srcAE     <= '0;
            srcBE     <= '0;
            stdataE   <= '0;
            regwriteE <= 1'b0;
            memreadE  <= 1'b0;
            memwriteE <= 1'b0;
        end else begin
            squash_q  <= BranchD;
            opE       <= nxt_op;
            rdE       <= nxt_rd;
            srcAE     <= nxt_a;
            srcBE     <= nxt_b;
            stdataE   <= nxt_st;
            regwriteE <= nxt_rw;
            memreadE  <= nxt_mr;
            memwriteE <= nxt_mw;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, mid-run reset, then random stimulus
// checked against a register-array reference model.
module tb_id_ex_stage;
    logic        clk;
    logic        rst_n;
    logic [18:0] InstrD;
    logic [7:0]  PCPlus1;
    logic        BranchD;
    logic [7:0]  PCBranch_Addr;
    logic        ex_wr_en;
    logic [3:0]  ex_wr_addr;
    logic [18:0] ex_result;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [18:0] wb_data;
    logic [4:0]  opE;
    logic [3:0]  rdE;
    logic [18:0] srcAE, srcBE, stdataE;
    logic        regwriteE, memreadE, memwriteE;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus1(PCPlus1),
        .BranchD(BranchD), .PCBranch_Addr(PCBranch_Addr),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .opE(opE), .rdE(rdE), .srcAE(srcAE), .srcBE(srcBE), .stdataE(stdataE),
        .regwriteE(regwriteE), .memreadE(memreadE), .memwriteE(memwriteE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [7:0]  tgt;
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [18:0] a, b, st;
        logic        rw, mr, mw;
        logic        crd, ca, cb, cs;
    } exp_t;

    typedef struct {
        logic [18:0] instr;
        logic [7:0]  pc;
        logic        exen;
        logic [3:0]  exa;
        logic [18:0] exr;
        logic        wbe;
        logic [3:0]  wba;
        logic [18:0] wbd;
        exp_t        e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    logic [18:0] mregs [16];
    logic        msq;

    function automatic logic [18:0] enc_r(int op, int rd, int rs1, int rs2);
        return {5'(op), 4'(rd), 4'(rs1), 4'(rs2), 2'b00};
    endfunction

    function automatic logic [18:0] enc_i(int op, int rd, int rs1, int imm);
        return {5'(op), 4'(rd), 4'(rs1), 6'(imm)};
    endfunction

    function automatic logic [18:0] enc_j(int abs);
        return {5'h0B, 6'h00, 8'(abs)};
    endfunction

    function automatic exp_t mk(int br, int tgt, int op, int rd, int a, int b, int st,
                                int rw, int mr, int mw, int crd, int ca, int cb, int cs);
        exp_t e;
        e.br = 1'(br);   e.tgt = 8'(tgt); e.op = 5'(op); e.rd = 4'(rd);
        e.a  = 19'(a);   e.b   = 19'(b);  e.st = 19'(st);
        e.rw = 1'(rw);   e.mr  = 1'(mr);  e.mw = 1'(mw);
        e.crd = 1'(crd); e.ca  = 1'(ca);  e.cb = 1'(cb); e.cs = 1'(cs);
        return e;
    endfunction

    function automatic exp_t bub(int pc);
        return mk(0, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(input logic [18:0] instr, input int pc, input int exen, input int exa,
                       input int exr, input int wbe, input int wba, input int wbd, input exp_t e);
        vec_t v;
        v.instr = instr; v.pc = 8'(pc);
        v.exen = 1'(exen); v.exa = 4'(exa); v.exr = 19'(exr);
        v.wbe  = 1'(wbe);  v.wba = 4'(wba); v.wbd = 19'(wbd);
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic comp_comb(input exp_t e);
        chk("BranchD", 19'(BranchD), 19'(e.br));
        chk("PCBranch_Addr", 19'(PCBranch_Addr), 19'(e.tgt));
    endtask

    task automatic comp_reg(input exp_t e);
        chk("opE", 19'(opE), 19'(e.op));
        chk("regwriteE", 19'(regwriteE), 19'(e.rw));
        chk("memreadE", 19'(memreadE), 19'(e.mr));
        chk("memwriteE", 19'(memwriteE), 19'(e.mw));
        if (e.crd) chk("rdE", 19'(rdE), 19'(e.rd));
        if (e.ca)  chk("srcAE", srcAE, e.a);
        if (e.cb)  chk("srcBE", srcBE, e.b);
        if (e.cs)  chk("stdataE", stdataE, e.st);
    endtask

    task automatic drive(input vec_t v);
        InstrD = v.instr; PCPlus1 = v.pc;
        ex_wr_en = v.exen; ex_wr_addr = v.exa; ex_result = v.exr;
        wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
    endtask

    function automatic logic [18:0] mread(input logic [3:0] a, input vec_t v);
        if (a == 4'd0) return 19'd0;
        if (v.exen && v.exa == a) return v.exr;
        if (v.wbe && v.wba == a) return v.wbd;
        return mregs[a];
    endfunction

    // Reference: what the slot should produce, from the instruction-set rules.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          op, simm;
        logic [18:0] rdv, rs1v, rs2v;
        logic        taken;
        op   = int'(v.instr[18:14]);
        simm = int'($signed(v.instr[5:0]));
        rdv  = mread(v.instr[13:10], v);
        rs1v = mread(v.instr[9:6], v);
        rs2v = mread(v.instr[5:2], v);
        taken = (op == 9 && rdv == rs1v) || (op == 10 && rdv != rs1v) || op == 11;
        e = bub(int'(v.pc));
        e.br = !msq && taken;
        if (e.br) e.tgt = (op == 11) ? v.instr[7:0] : 8'((int'(v.pc) + simm) & 255);
        if (!msq) begin
            e.op  = (op <= 11) ? 5'(op) : 5'd0;
            e.rd  = v.instr[13:10];
            e.crd = (op <= 11);
            e.rw  = (op >= 1 && op <= 7);
            e.mr  = (op == 7);
            e.mw  = (op == 8);
            e.ca  = (op >= 1 && op <= 8);
            e.cb  = e.ca;
            e.a   = rs1v;
            e.b   = (op <= 5) ? rs2v : 19'(simm);
            e.cs  = (op == 8);
            e.st  = rdv;
        end
        return e;
    endfunction

    task automatic run_table(input vec_t v);
        drive(v);
        #1 comp_comb(v.e);
        @(posedge clk);
        #1 comp_reg(v.e);
        @(negedge clk);
    endtask

    task automatic run_model(input vec_t v);
        exp_t e;
        drive(v);
        #1 e = model(v);
        comp_comb(e);
        @(posedge clk);
        #1 comp_reg(e);
        if (v.wbe && v.wba != 4'd0) mregs[v.wba] = v.wbd;
        msq = e.br;
        @(negedge clk);
    endtask

    function automatic logic [18:0] rnd_val();
        return ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 3)) : 19'($urandom);
    endfunction

    initial begin
        vec_t v;
        rst_n = 1'b0; InstrD = '0; PCPlus1 = '0;
        ex_wr_en = 1'b0; ex_wr_addr = '0; ex_result = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        add(enc_r(0, 0, 0, 0), 8'h00, 0, 0, 0, 1, 3, 5, bub(0));
        add(enc_r(0, 0, 0, 0), 8'h00, 0, 0, 0, 1, 4, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r(1, 1, 3, 4), 8'h00, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 5, 7, 0, 1, 0, 0, 1, 1, 1, 0));
        add(enc_i(6, 5, 2, -1), 8'h00, 1, 2, 9, 1, 2, 4, mk(0, 0, 6, 5, 9, 'h7FFFF, 0, 1, 0, 0, 1, 1, 1, 0));
        add(enc_i(6, 6, 2, 1), 8'h00, 0, 0, 0, 0, 0, 0, mk(0, 0, 6, 6, 4, 1, 0, 1, 0, 0, 1, 1, 1, 0));
        add(enc_i(7, 7, 3, 2), 8'h00, 0, 0, 0, 0, 0, 0, mk(0, 0, 7, 7, 5, 2, 0, 1, 1, 0, 1, 1, 1, 0));
        add(enc_i(8, 4, 3, -2), 8'h00, 0, 0, 0, 0, 0, 0, mk(0, 0, 8, 4, 5, 'h7FFFE, 7, 0, 0, 1, 1, 1, 1, 1));
        add(enc_i(9, 1, 1, -3), 8'h01, 0, 0, 0, 0, 0, 0, mk(1, 'hFE, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r(1, 1, 3, 4), 8'h02, 0, 0, 0, 0, 0, 0, bub('h02));
        add(enc_j('h40), 8'h03, 0, 0, 0, 0, 0, 0, mk(1, 'h40, 'hB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_j('h80), 8'h41, 0, 0, 0, 0, 0, 0, bub('h41));
        add(enc_r(0, 0, 0, 0), 8'h81, 0, 0, 0, 1, 0, 'h7FFFF, mk(0, 'h81, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r('h1F, 0, 0, 0), 8'h82, 0, 0, 0, 0, 0, 0, mk(0, 'h82, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r(1, 9, 0, 3), 8'h83, 1, 0, 123, 1, 0, 55, mk(0, 'h83, 1, 9, 0, 5, 0, 1, 0, 0, 1, 1, 1, 0));
        add(enc_i('hA, 3, 4, 5), 8'h10, 0, 0, 0, 0, 0, 0, mk(1, 'h15, 'hA, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r(0, 0, 0, 0), 8'h11, 0, 0, 0, 0, 0, 0, bub('h11));
        add(enc_i('hA, 3, 3, 5), 8'h20, 0, 0, 0, 0, 0, 0, mk(0, 'h20, 'hA, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_i(9, 4, 5, 'h20), 8'h10, 1, 5, 7, 0, 0, 0, mk(1, 'hF0, 9, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(enc_r(0, 0, 0, 0), 8'h11, 0, 0, 0, 0, 0, 0, bub('h11));
        add(enc_r(5, 10, 3, 4), 8'h12, 0, 0, 0, 0, 0, 0, mk(0, 'h12, 5, 10, 5, 7, 0, 1, 0, 0, 1, 1, 1, 0));
        add(enc_r(1, 11, 8, 3), 8'h13, 0, 0, 0, 1, 8, 'h12345, mk(0, 'h13, 1, 11, 'h12345, 5, 0, 1, 0, 0, 1, 1, 1, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) run_table(tbl[i]);

        // Asynchronous reset mid-run: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst opE", 19'(opE), 19'd0);
        chk("rst rdE", 19'(rdE), 19'd0);
        chk("rst srcAE", srcAE, 19'd0);
        chk("rst srcBE", srcBE, 19'd0);
        chk("rst stdataE", stdataE, 19'd0);
        chk("rst regwriteE", 19'(regwriteE), 19'd0);
        chk("rst memreadE", 19'(memreadE), 19'd0);
        chk("rst memwriteE", 19'(memwriteE), 19'd0);
        chk("rst BranchD", 19'(BranchD), 19'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = 19'd0;
        msq = 1'b1;

        // First slot after release holds a jump that must be ignored.
        v.instr = enc_j('h55); v.pc = 8'h07;
        v.exen = 1'b0; v.exa = '0; v.exr = '0;
        v.wbe = 1'b0;  v.wba = '0; v.wbd = '0;
        run_model(v);

        for (int n = 0; n < 800; n++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r > 12) r = int'($urandom_range(12, 31));
            v.instr = {5'(r), 14'($urandom)};
            v.pc    = 8'($urandom);
            v.exen  = ($urandom_range(0, 2) == 0);
            v.exa   = 4'($urandom);
            v.exr   = rnd_val();
            v.wbe   = ($urandom_range(0, 1) == 0);
            v.wba   = 4'($urandom);
            v.wbd   = rnd_val();
            run_model(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
